pool2x2_stream: RTL and testbench
=================================

Name: pool2x2_stream

Overview:
Parametrised 2×2 stride-2 pooling stage for the grayscale pixel pipeline. Run-time selectable max or rounded-average mode, configurable pixel width and image geometry. Explicit frame state and end-of-line/end-of-frame markers. Sits between the grayscale/resize stages and downstream feature logic; can be cascaded (e.g. 112→56→28).

Parameters:
DATA_W, 8, pixel bit width (≥1)
IN_WIDTH, 112, input pixels per line; must be even, ≥2
IN_HEIGHT, 112, input lines per frame; must be even, ≥2

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  reset, asynchronous, active-high
frame_start  input  1  one-cycle pulse; marks the same-cycle pixel as pixel (0,0) if valid
mode  input  1  0 = max, 1 = average; sampled only on frame_start
pixel_in  input  DATA_W  input pixel
pixel_valid_in  input  1  pixel_in valid this cycle
pixel_out  output  DATA_W  pooled pixel
pixel_valid_out  output  1  pixel_out valid (one-cycle strobe per output pixel)
line_end_out  output  1  high with the last output pixel of each output line
frame_done  output  1  high with the last output pixel of the frame
busy  output  1  high while a frame is in progress (RUN state)

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; counters 0; mode register 0; line-buffer contents don't-care, never read before being written in a frame.
- States: IDLE → RUN on frame_start; RUN → DONE when the pixel at (IN_HEIGHT-1, IN_WIDTH-1) is accepted; DONE → RUN on frame_start. frame_start in RUN aborts the current frame: counters restart, no partial output, frame_done not asserted.
- IDLE/DONE: pixel_valid_in without frame_start is ignored; no output.
- Cycle with frame_start and pixel_valid_in: pixel accepted as (0,0) of the new frame.
- Counters: col 0..IN_WIDTH-1, row 0..IN_HEIGHT-1; advance only on accepted pixels; col wraps to 0 and row increments at IN_WIDTH-1. Gaps in pixel_valid_in are allowed anywhere, including mid-pair.
- Horizontal stage: even col pixel held in a register; odd col combines with it: max mode → max(a,b); avg mode → a+b (DATA_W+1 bits).
- Even row: combined pair written to line buffer entry col/2 (IN_WIDTH/2 entries, DATA_W+1 bits).
- Odd row, odd col: combine pair with buffer entry col/2: max → max of both; avg → (sum4 + 2) >> 2, sum4 DATA_W+2 bits, round-half-up, result always fits DATA_W.
- Latency: pixel_valid_out asserted exactly 1 cycle after the accepting cycle of the odd-row/odd-col pixel; pixel_out held until the next output; valid is a single-cycle pulse.
- line_end_out co-asserted when the source col = IN_WIDTH-1; frame_done additionally when the source row = IN_HEIGHT-1.
- Output count per frame: (IN_WIDTH/2)×(IN_HEIGHT/2).
- Back-to-back frames: frame_start one cycle after the last input pixel is legal; the pending output and frame_done still emit.
- busy = 1 in RUN, 0 in IDLE/DONE; rises the cycle after frame_start.
- Elaboration check: odd IN_WIDTH or odd IN_HEIGHT is a fatal error.

Decomposition:
- Shared package pool_pkg: mode encoding constants (POOL_MAX = 0, POOL_AVG = 1), state encodings (IDLE/RUN/DONE), function clog2 for counter widths.
- One sub-module pool_pair_op: combinational max/sum of two operands with parametrised width. Instantiated for the horizontal and vertical combine stages.
- Line buffer is inferred inline as a simple dual-port RAM (one write, one read per cycle).

Test Plan:
- 4×4 frame (IN_WIDTH=IN_HEIGHT=4), max mode, raster values 0..15 → outputs 5, 7, 13, 15; line_end_out on the 2nd and 4th outputs; frame_done on the 4th output only.
- Same frame, avg mode → outputs 3 (10/4 = 2.5 rounds up), 5, 11, 13; each 1 cycle after the source pixel.
- DATA_W=8, avg mode, all pixels 255 → all outputs 255 (no overflow). Pixels {1,0,0,0} per window → 0; {1,1,0,0} → 1.
- Random pixel_valid_in gaps (≈50% duty), 112×112 max mode → 3136 outputs matching the reference model; none emitted after frame_done until the next frame_start.
- frame_start mid-frame at row 2, col 1 → no stale output; new frame's first output is computed from new pixels only. Pixels in IDLE before the first frame_start are ignored.
- Assert rst mid-frame → all outputs 0 immediately (async). After release, pixels ignored until frame_start; mode toggled mid-frame has no effect until the next frame_start.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared mode/state encodings and width helper for the 2x2 pooling stage
package pool_pkg;
    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int clog2(input int n);
        for (int r = 1; r < 31; r++)
            if ((1 << r) >= n) return r;
        return 31;
    endfunction
endpackage

// File: rtl/pool2x2_stream_if.sv
// pool2x2_stream_if: pixel stream in/out bundle for the pooling stage
interface pool2x2_stream_if #(parameter int DATA_W = 8);
    logic              frame_start;
    logic              mode;
    logic [DATA_W-1:0] pixel_in;
    logic              pixel_valid_in;
    logic [DATA_W-1:0] pixel_out;
    logic              pixel_valid_out;
    logic              line_end_out;
    logic              frame_done;
    logic              busy;
    modport master (
        output frame_start, mode, pixel_in, pixel_valid_in,
        input  pixel_out, pixel_valid_out, line_end_out, frame_done, busy
    );
    modport slave (
        input  frame_start, mode, pixel_in, pixel_valid_in,
        output pixel_out, pixel_valid_out, line_end_out, frame_done, busy
    );
endinterface

// File: rtl/pool_pair_op.sv
// pool_pair_op: combinational max or widened sum of two operands
module pool_pair_op import pool_pkg::*; #(
    parameter int W = 8
) (
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   y
);
    assign y = mode == POOL_AVG ? {1'b0, a} + {1'b0, b} : {1'b0, a > b ? a : b};
endmodule

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: 2x2 stride-2 max/rounded-average pooling over a raster pixel stream
module pool2x2_stream import pool_pkg::*; #(
    parameter int DATA_W    = 8,
    parameter int IN_WIDTH  = 112,
    parameter int IN_HEIGHT = 112
) (
    input logic              clk,
    input logic              rst,
    pool2x2_stream_if.slave  st
);
    localparam int HW = IN_WIDTH / 2;
    localparam int CW = clog2(IN_WIDTH);
    localparam int RW = clog2(IN_HEIGHT);
    localparam int AW = clog2(HW);

    if ((IN_WIDTH % 2) != 0 || (IN_HEIGHT % 2) != 0 || IN_WIDTH < 2 || IN_HEIGHT < 2) begin : g_bad_geom
        $fatal(1, "pool2x2_stream: IN_WIDTH and IN_HEIGHT must be even and >= 2");
    end

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              mode_r;
    logic [DATA_W-1:0] hold;
    logic [DATA_W:0]   lb [HW];

    logic              accept, run_mode, last_col, last_row;
    logic [CW-1:0]     c;
    logic [RW-1:0]     r;
    logic [AW-1:0]     idx;
    logic [DATA_W:0]   h;
    logic [DATA_W+1:0] v;
    logic [DATA_W-1:0] pooled;

    // frame_start overrides the stored position and mode so its own pixel is (0,0) of the new frame
    assign accept   = st.pixel_valid_in && (st.frame_start || state == RUN);
    assign c        = st.frame_start ? '0 : col;
    assign r        = st.frame_start ? '0 : row;
    assign run_mode = st.frame_start ? st.mode : mode_r;
    assign idx      = AW'(c >> 1);
    assign last_col = c == CW'(IN_WIDTH - 1);
    assign last_row = r == RW'(IN_HEIGHT - 1);
    assign pooled   = run_mode == POOL_AVG ? DATA_W'((v + 2) >> 2) : v[DATA_W-1:0];
    assign st.busy  = state == RUN;

    pool_pair_op #(.W(DATA_W))     u_h (.mode(run_mode), .a(hold), .b(st.pixel_in), .y(h));
    pool_pair_op #(.W(DATA_W + 1)) u_v (.mode(run_mode), .a(h),    .b(lb[idx]),     .y(v));

    always_ff @(posedge clk)
        if (accept && !r[0] && c[0]) lb[idx] <= h;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            col                <= '0;
            row                <= '0;
            mode_r             <= POOL_MAX;
            hold               <= '0;
            st.pixel_out       <= '0;
            st.pixel_valid_out <= 1'b0;
            st.line_end_out    <= 1'b0;
            st.frame_done      <= 1'b0;
        end else begin
            st.pixel_valid_out <= accept && r[0] && c[0];
            st.line_end_out    <= accept && r[0] && last_col;
            st.frame_done      <= accept && last_row && last_col;
            if (st.frame_start) begin
                state  <= RUN;
                mode_r <= st.mode;
                col    <= '0;
                row    <= '0;
            end
            if (accept) begin
                if (!c[0]) hold <= st.pixel_in;
                if (r[0] && c[0]) st.pixel_out <= pooled;
                col <= last_col ? '0 : c + 1'b1;
                row <= last_col ? (last_row ? '0 : r + 1'b1) : r;
                if (last_col && last_row) state <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_pool2x2_stream.sv
// tb_pool2x2_stream: random-stimulus check of a 4x4 and a 112x112 pooling stage against a window model
module tb_pool2x2_stream;
    typedef struct {int val; bit le; bit fd; int due;} exp_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int gw[2] = '{4, 112};
    int gh[2] = '{4, 112};
    int last[2] = '{0, 0};
    int img[112][112];
    exp_t q[2][$];

    logic       fs[2], md[2], pv[2];
    logic [7:0] pin[2];
    logic       ov[2], ole[2], ofd[2], obusy[2];
    logic [7:0] od[2];

    pool2x2_stream_if #(.DATA_W(8)) sif ();
    pool2x2_stream_if #(.DATA_W(8)) lif ();

    assign sif.frame_start = fs[0];
    assign sif.mode = md[0];
    assign sif.pixel_in = pin[0];
    assign sif.pixel_valid_in = pv[0];
    assign lif.frame_start = fs[1];
    assign lif.mode = md[1];
    assign lif.pixel_in = pin[1];
    assign lif.pixel_valid_in = pv[1];
    assign ov[0] = sif.pixel_valid_out;
    assign ole[0] = sif.line_end_out;
    assign ofd[0] = sif.frame_done;
    assign obusy[0] = sif.busy;
    assign od[0] = sif.pixel_out;
    assign ov[1] = lif.pixel_valid_out;
    assign ole[1] = lif.line_end_out;
    assign ofd[1] = lif.frame_done;
    assign obusy[1] = lif.busy;
    assign od[1] = lif.pixel_out;

    pool2x2_stream #(.DATA_W(8), .IN_WIDTH(4), .IN_HEIGHT(4)) dut_s (.clk(clk), .rst(rst), .st(sif));
    pool2x2_stream #(.DATA_W(8), .IN_WIDTH(112), .IN_HEIGHT(112)) dut_l (.clk(clk), .rst(rst), .st(lif));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // pooled value of the 2x2 window whose top-left pixel is (r,c)
    function automatic int win(input int r, input int c, input bit m);
        int s[4];
        int mx;
        s = '{img[r][c], img[r][c+1], img[r+1][c], img[r+1][c+1]};
        mx = 0;
        foreach (s[k]) if (s[k] > mx) mx = s[k];
        return m ? (s[0] + s[1] + s[2] + s[3] + 2) / 4 : mx;
    endfunction

    task automatic fill_rand(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) img[r][c] = int'($urandom_range(255));
    endtask

    // drives one frame (or its first `stop` pixels) and queues every output it must produce
    task automatic send_frame(input int i, input bit m, input int gap, input int stop);
        int w, h;
        w = gw[i];
        h = gh[i];
        for (int n = 0; n < w * h; n++) begin
            int r, c;
            r = n / w;
            c = n % w;
            if (n == stop) break;
            while (n > 0 && int'($urandom_range(99)) < gap) begin
                pv[i] = 0;
                fs[i] = 0;
                pin[i] = 8'($urandom);
                @(posedge clk); #1;
            end
            fs[i] = (n == 0);
            md[i] = (n == 0) ? m : ~m;
            pin[i] = 8'(img[r][c]);
            pv[i] = 1;
            if (r % 2 == 1 && c % 2 == 1)
                q[i].push_back('{win(r - 1, c - 1, m), c == w - 1, r == h - 1 && c == w - 1, cyc + 1});
            @(posedge clk); #1;
            if (n == 0) check($sformatf("busy_rise[%0d]", i), obusy[i], 1);
        end
        pv[i] = 0;
        fs[i] = 0;
        if (stop < 0) check($sformatf("busy_done[%0d]", i), obusy[i], 0);
    endtask

    task automatic idle_pixels(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            fs[i] = 0;
            pv[i] = 1'($urandom);
            md[i] = 1'($urandom);
            pin[i] = 8'($urandom);
            @(posedge clk); #1;
        end
        pv[i] = 0;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit ev;
            ev = q[i].size() > 0 && q[i][0].due == cyc;
            check($sformatf("valid[%0d]", i), ov[i], ev);
            if (ev) begin
                check($sformatf("pixel[%0d]", i), od[i], q[i][0].val);
                check($sformatf("line_end[%0d]", i), ole[i], q[i][0].le);
                check($sformatf("frame_done[%0d]", i), ofd[i], q[i][0].fd);
                last[i] = q[i][0].val;
                void'(q[i].pop_front());
            end else begin
                check($sformatf("hold[%0d]", i), od[i], last[i]);
                check($sformatf("line_end_idle[%0d]", i), ole[i], 0);
                check($sformatf("frame_done_idle[%0d]", i), ofd[i], 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            fs[i] = 0; md[i] = 0; pv[i] = 0; pin[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_pixel[%0d]", i), od[i], 0);
            check($sformatf("rst_valid[%0d]", i), ov[i], 0);
            check($sformatf("rst_busy[%0d]", i), obusy[i], 0);
        end
        rst = 0;
        idle_pixels(0, 6);
        idle_pixels(1, 6);
        check("idle_busy", obusy[0], 0);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r][c] = r * 4 + c;
        check("model_max_00", win(0, 0, 0), 5);
        check("model_max_02", win(0, 2, 0), 7);
        check("model_max_20", win(2, 0, 0), 13);
        check("model_max_22", win(2, 2, 0), 15);
        check("model_avg_00", win(0, 0, 1), 3);
        check("model_avg_02", win(0, 2, 1), 5);
        check("model_avg_20", win(2, 0, 1), 11);
        check("model_avg_22", win(2, 2, 1), 13);
        send_frame(0, 0, 0, -1);
        send_frame(0, 1, 0, -1);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r][c] = 255;
        check("model_avg_255", win(0, 0, 1), 255);
        send_frame(0, 1, 30, -1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r][c] = (r % 2 == 0 && c % 2 == 0) ? 1 : 0;
        check("model_avg_1000", win(0, 0, 1), 0);
        send_frame(0, 1, 0, -1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r][c] = (r % 2 == 0) ? 1 : 0;
        check("model_avg_1100", win(0, 0, 1), 1);
        send_frame(0, 1, 0, -1);

        for (int k = 0; k < 4; k++) begin
            fill_rand(4, 4);
            send_frame(0, 1'(k), 50, -1);
        end

        fill_rand(4, 4);
        send_frame(0, 0, 20, 9);
        fill_rand(4, 4);
        send_frame(0, 1, 0, -1);

        // async reset in the middle of a frame, with pixel_out holding a non-zero value
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r][c] = (r * 4 + c) * 10 + 5;
        send_frame(0, 0, 0, 13);
        repeat (2) @(posedge clk);
        #2;
        rst = 1;
        #1;
        check("arst_pixel", od[0], 0);
        check("arst_valid", ov[0], 0);
        check("arst_busy", obusy[0], 0);
        check("arst_line_end", ole[0], 0);
        q[0].delete();
        last[0] = 0;
        @(posedge clk); #1;
        rst = 0;
        idle_pixels(0, 8);
        check("post_rst_busy", obusy[0], 0);
        fill_rand(4, 4);
        send_frame(0, 1, 0, -1);

        fill_rand(112, 112);
        send_frame(1, 0, 50, -1);
        idle_pixels(1, 20);

        repeat (5) @(posedge clk);
        #1;
        check("drain_s", q[0].size(), 0);
        check("drain_l", q[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
